// File: rtl/mlp_disp_pkg.sv
// Shared types and constants for the perceptron argmax / 7-segment output stage.
package mlp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high; dp never lit.
  localparam logic [7:0] SEG7_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/mlp_argmax_disp_if.sv
// Score stream into the argmax stage: frame start pulse plus valid-qualified scores.
interface mlp_argmax_disp_if #(
  parameter int SCORE_W = 8
);
  logic               START_I;
  logic               SCORE_VALID_I;
  logic [SCORE_W-1:0] SCORE_I;

  modport master (output START_I, output SCORE_VALID_I, output SCORE_I);
  modport slave  (input  START_I, input  SCORE_VALID_I, input  SCORE_I);
endinterface

// File: rtl/mlp_argmax_disp_seg7_dec.sv
// Hex nibble to 7-segment pattern, optional active-low output.
module seg7_dec
  import mlp_disp_pkg::*;
#(
  parameter bit SEG_INV = 1'b0
) (
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  // Table lookup with optional polarity inversion
  always_comb begin
    seg = SEG7_LUT[digit];
    if (SEG_INV) begin
      seg = ~SEG7_LUT[digit];
    end else begin
      seg = SEG7_LUT[digit];
    end
  end

endmodule

// File: rtl/mlp_argmax_disp.sv
// Tracks best/second-best L2 score per frame, reports the winning class and
// drives class digit and saturated confidence margin to two 7-seg displays.
module mlp_argmax_disp
  import mlp_disp_pkg::*;
#(
  parameter int N_CLASS      = 10,
  parameter int SCORE_W      = 8,
  parameter int MARGIN_SHIFT = 0,
  parameter bit SEG_INV      = 1'b0
) (
  input  logic                    CK,
  input  logic                    RB,
  mlp_argmax_disp_if.slave        s_if,
  output logic                    BUSY_O,
  output logic [3:0]              CLASS_O,
  output logic                    CLASS_VALID_O,
  output logic                    ERR_O,
  output logic [7:0]              SEG_0,
  output logic [7:0]              SEG_1
);

  localparam logic [1:0]         ST_IDLE   = IDLE;
  localparam logic [1:0]         ST_ACCUM  = ACCUM;
  localparam logic [1:0]         ST_DONE   = DONE;
  localparam logic [3:0]         LAST_IDX  = 4'(N_CLASS - 1);
  localparam logic [7:0]         BLANK_VAL = SEG_INV ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [SCORE_W-1:0] MOST_NEG  = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [SCORE_W:0]   SAT_MAX   = {{(SCORE_W-3){1'b0}}, 4'hF};

  logic [1:0]                state_r;
  logic [3:0]                count_r;
  logic [3:0]                idx_r;
  logic signed [SCORE_W-1:0] best_r;
  logic signed [SCORE_W-1:0] second_r;
  logic                      finish_r;
  logic [3:0]                class_r;
  logic                      class_valid_r;
  logic                      err_r;
  logic [7:0]                seg0_r;
  logic [7:0]                seg1_r;

  logic signed [SCORE_W-1:0] score_s;
  logic [SCORE_W:0]          diff_s;
  logic [SCORE_W:0]          shifted_s;
  logic [3:0]                margin_s;
  logic [7:0]                seg0_s;
  logic [7:0]                seg1_s;

  assign score_s = $signed(s_if.SCORE_I);

  // Margin is best minus second in one extra bit so it never wraps
  always_comb begin
    diff_s    = {best_r[SCORE_W-1], best_r} - {second_r[SCORE_W-1], second_r};
    shifted_s = diff_s >> MARGIN_SHIFT;
    if (shifted_s > SAT_MAX) begin
      margin_s = 4'hF;
    end else begin
      margin_s = shifted_s[3:0];
    end
  end

  seg7_dec #(.SEG_INV(SEG_INV)) u_dec_class  (.digit(idx_r),    .seg(seg0_s));
  seg7_dec #(.SEG_INV(SEG_INV)) u_dec_margin (.digit(margin_s), .seg(seg1_s));

  // Frame FSM, running argmax, and registered result/display outputs
  always_ff @(posedge CK) begin
    if (!RB) begin
      state_r       <= ST_IDLE;
      count_r       <= 4'd0;
      idx_r         <= 4'd0;
      best_r        <= MOST_NEG;
      second_r      <= MOST_NEG;
      finish_r      <= 1'b0;
      class_r       <= 4'd0;
      class_valid_r <= 1'b0;
      err_r         <= 1'b0;
      seg0_r        <= BLANK_VAL;
      seg1_r        <= BLANK_VAL;
    end else begin
      class_valid_r <= 1'b0;
      finish_r      <= 1'b0;
      if (finish_r) begin
        class_r       <= idx_r;
        class_valid_r <= 1'b1;
        seg0_r        <= seg0_s;
        seg1_r        <= seg1_s;
      end
      // A start always wins over a coincident score, which is dropped
      if (s_if.START_I) begin
        state_r  <= ST_ACCUM;
        count_r  <= 4'd0;
        idx_r    <= 4'd0;
        best_r   <= MOST_NEG;
        second_r <= MOST_NEG;
        err_r    <= 1'b0;
      end else if (s_if.SCORE_VALID_I) begin
        if (state_r == ST_ACCUM) begin
          if (score_s > best_r) begin
            second_r <= best_r;
            best_r   <= score_s;
            idx_r    <= count_r;
          end else if (score_s > second_r) begin
            second_r <= score_s;
          end
          count_r <= count_r + 4'd1;
          if (count_r == LAST_IDX) begin
            state_r  <= ST_DONE;
            finish_r <= 1'b1;
          end
        end else begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign BUSY_O        = (state_r == ST_ACCUM);
  assign CLASS_O       = class_r;
  assign CLASS_VALID_O = class_valid_r;
  assign ERR_O         = err_r;
  assign SEG_0         = seg0_r;
  assign SEG_1         = seg1_r;

endmodule

// File: tb/tb_mlp_argmax_disp.sv
// Directed bench for mlp_argmax_disp; a second instance with SEG_INV=1 shares the stimulus.
module tb_mlp_argmax_disp;

  logic       CK = 1'b0;
  logic       RB = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         strobe_cnt = 0;
  int         snap;

  logic       busy0, cv0, err0, busy1, cv1, err1;
  logic [3:0] cls0, cls1;
  logic [7:0] s00, s01, s10, s11;

  logic [7:0] t1 [10] = '{8'hFB, 8'd3, 8'd12, 8'd7, 8'h80, 8'd0, 8'd1, 8'd2, 8'd11, 8'd4};
  logic [7:0] t2 [10] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
  logic [7:0] t3 [10] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
  int         gaps [10] = '{1, 0, 2, 0, 3, 1, 0, 2, 1, 0};

  mlp_argmax_disp_if #(.SCORE_W(8)) sif ();

  mlp_argmax_disp #(.N_CLASS(10), .SCORE_W(8), .MARGIN_SHIFT(0), .SEG_INV(1'b0)) dut0 (
    .CK(CK), .RB(RB), .s_if(sif), .BUSY_O(busy0), .CLASS_O(cls0),
    .CLASS_VALID_O(cv0), .ERR_O(err0), .SEG_0(s00), .SEG_1(s01));

  mlp_argmax_disp #(.N_CLASS(10), .SCORE_W(8), .MARGIN_SHIFT(0), .SEG_INV(1'b1)) dut1 (
    .CK(CK), .RB(RB), .s_if(sif), .BUSY_O(busy1), .CLASS_O(cls1),
    .CLASS_VALID_O(cv1), .ERR_O(err1), .SEG_0(s10), .SEG_1(s11));

  always #5 CK = ~CK;

  always @(posedge CK) begin
    if (cv0 === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    sif.START_I = 1'b1;
    @(negedge CK);
    sif.START_I = 1'b0;
  endtask

  task automatic send(input logic [7:0] s, input int gap);
    sif.SCORE_VALID_I = 1'b1;
    sif.SCORE_I       = s;
    @(negedge CK);
    sif.SCORE_VALID_I = 1'b0;
    repeat (gap) @(negedge CK);
  endtask

  task automatic send_frame(input logic [7:0] sc [10]);
    for (int i = 0; i < 10; i++) send(sc[i], gaps[i]);
  endtask

  initial begin
    sif.START_I = 1'b0;
    sif.SCORE_VALID_I = 1'b0;
    sif.SCORE_I = 8'd0;
    repeat (2) @(negedge CK);
    RB = 1'b1;

    // reset defaults
    check("rst_busy", busy0, 1'b0);
    check("rst_class", cls0, 4'd0);
    check("rst_cv", cv0, 1'b0);
    check("rst_err", err0, 1'b0);
    check("rst_seg0", s00, 8'h00);
    check("rst_seg1", s01, 8'h00);
    check("rst_inv_seg0", s10, 8'hFF);

    // test 1: mixed scores with gaps
    pulse_start();
    check("t1_busy", busy0, 1'b1);
    send_frame(t1);
    check("t1_cv_early", cv0, 1'b0);
    check("t1_busy_done", busy0, 1'b0);
    @(negedge CK);
    check("t1_cv", cv0, 1'b1);
    check("t1_class", cls0, 4'd2);
    check("t1_seg0", s00, 8'h5B);
    check("t1_seg1", s01, 8'h06);
    check("t1_busy_after", busy0, 1'b0);
    @(negedge CK);
    check("t1_cv_one_cycle", cv0, 1'b0);
    check("t1_class_hold", cls0, 4'd2);

    // test 2: all ties
    pulse_start();
    send_frame(t2);
    @(negedge CK);
    check("t2_cv", cv0, 1'b1);
    check("t2_class", cls0, 4'd0);
    check("t2_seg0", s00, 8'h3F);
    check("t2_seg1", s01, 8'h3F);

    // test 3: saturated margin, both polarities
    pulse_start();
    send_frame(t3);
    @(negedge CK);
    check("t3_class", cls0, 4'd9);
    check("t3_seg0", s00, 8'h6F);
    check("t3_seg1", s01, 8'h71);
    check("t3_inv_seg0", s10, 8'h90);
    check("t3_inv_seg1", s11, 8'h8E);
    check("t3_inv_class", cls1, 4'd9);

    // test 4: abort after 4 scores
    @(negedge CK);
    snap = strobe_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'd100, 0);
    pulse_start();
    check("t4_busy_restart", busy0, 1'b1);
    send_frame(t1);
    @(negedge CK);
    check("t4_cv", cv0, 1'b1);
    check("t4_class", cls0, 4'd2);
    check("t4_seg1", s01, 8'h06);
    @(negedge CK);
    check("t4_strobes", strobe_cnt - snap, 32'd1);

    // test 5: score outside a frame, then start clears; start+valid drops score
    send(8'h7F, 0);
    check("t5_err", err0, 1'b1);
    check("t5_class_hold", cls0, 4'd2);
    check("t5_seg0_hold", s00, 8'h5B);
    check("t5_cv", cv0, 1'b0);
    sif.SCORE_VALID_I = 1'b1;
    sif.SCORE_I = 8'h7F;
    pulse_start();
    sif.SCORE_VALID_I = 1'b0;
    check("t5_err_clr", err0, 1'b0);
    for (int i = 0; i < 9; i++) send(t1[i], 0);
    check("t5_busy_after9", busy0, 1'b1);
    send(t1[9], 0);
    @(negedge CK);
    check("t5_cv", cv0, 1'b1);
    check("t5_class", cls0, 4'd2);

    // test 6: reset mid-frame
    pulse_start();
    for (int i = 0; i < 6; i++) send(t1[i], 0);
    RB = 1'b0;
    @(negedge CK);
    RB = 1'b1;
    check("t6_busy", busy0, 1'b0);
    check("t6_seg0", s00, 8'h00);
    check("t6_seg1", s01, 8'h00);
    check("t6_class", cls0, 4'd0);
    check("t6_inv_seg1", s11, 8'hFF);
    send(8'd1, 0);
    check("t6_idle_err", err0, 1'b1);
    check("t6_idle_seg0", s00, 8'h00);
    pulse_start();
    send_frame(t1);
    @(negedge CK);
    check("t6_cv", cv0, 1'b1);
    check("t6_class", cls0, 4'd2);
    check("t6_seg0", s00, 8'h5B);
    check("t6_seg1", s01, 8'h06);
    check("t6_err", err0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
